// File: rtl/sat_engine_pkg.sv
// Shared types and parameter defaults for the SAT engine loader.
// Imported by the loader top and its watchdog.
package sat_engine_pkg;

    localparam int DEF_NUM_CLAUSES      = 8;
    localparam int DEF_NUM_VARS         = 8;
    localparam int DEF_NUM_LVLS         = 8;
    localparam int DEF_WIDTH_LVL        = 16;
    localparam int DEF_WIDTH_BIN_ID     = 10;
    localparam int DEF_WIDTH_VAR_STATES = 19;
    localparam int DEF_WIDTH_LVL_STATES = 11;
    localparam int DEF_MAX_CYCLES       = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_C,
        S_PAD_C,
        S_LOAD_VS,
        S_LOAD_LS,
        S_START,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/sat_watchdog.sv
// Run-phase cycle counter; flags the cycle whose edge
// brings the count up to MAX_CYCLES.
module sat_watchdog
    import sat_engine_pkg::*;
#(
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sat_engine_loader.sv
// Loads clause rows, var and level states into the SAT engine,
// starts it and collects its verdict under a watchdog.
module sat_engine_loader
    import sat_engine_pkg::*;
#(
    parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
    parameter int NUM_VARS         = DEF_NUM_VARS,
    parameter int NUM_LVLS         = DEF_NUM_LVLS,
    parameter int WIDTH_LVL        = DEF_WIDTH_LVL,
    parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
    parameter int WIDTH_VAR_STATES = DEF_WIDTH_VAR_STATES,
    parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES,
    parameter int MAX_CYCLES       = DEF_MAX_CYCLES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic [WIDTH_BIN_ID-1:0]                bin_id_i,
    input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_src_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_src_i,
    input  logic                                   clause_valid_i,
    input  logic                                   clause_last_i,
    input  logic [2*NUM_VARS-1:0]                  clause_data_i,
    output logic                                   clause_ready_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   sat_o,
    output logic                                   unsat_o,
    output logic                                   timeout_o,
    output logic                                   proto_err_o,
    output logic [WIDTH_LVL-1:0]                   bkt_lvl_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_result_o,
    output logic [NUM_CLAUSES-1:0]                 wr_carray_o,
    output logic [2*NUM_VARS-1:0]                  clause_o,
    output logic [NUM_VARS-1:0]                    wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_o,
    output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
    output logic                                   start_core_o,
    output logic [WIDTH_LVL-1:0]                   cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                   load_lvl_o,
    output logic [WIDTH_LVL-1:0]                   base_lvl_o,
    output logic                                   base_lvl_en_o,
    input  logic                                   done_core_i,
    input  logic                                   sat_i,
    input  logic                                   unsat_i,
    input  logic [WIDTH_LVL-1:0]                   bkt_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_eng_i
);

    localparam int VSW = WIDTH_VAR_STATES * NUM_VARS;
    localparam int LSW = WIDTH_LVL_STATES * NUM_LVLS;
    localparam int CLW = 2 * NUM_VARS;
    localparam int KW  = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CLAUSES - 1);

    state_e                  state_q;
    logic [KW-1:0]           k_q;
    logic [WIDTH_BIN_ID-1:0] bin_q;
    logic [WIDTH_LVL-1:0]    base_q;
    logic [VSW-1:0]          vs_q;
    logic [LSW-1:0]          ls_q;

    logic                    ready_q, busy_q, done_q;
    logic                    sat_q, unsat_q, tout_q, perr_q;
    logic [WIDTH_LVL-1:0]    bkt_q;
    logic [VSW-1:0]          vsres_q;
    logic [NUM_CLAUSES-1:0]  wrc_q;
    logic [CLW-1:0]          clause_q;
    logic [NUM_VARS-1:0]     wrvs_q;
    logic [VSW-1:0]          vso_q;
    logic [NUM_LVLS-1:0]     wrls_q;
    logic [LSW-1:0]          lso_q;
    logic                    stc_q;
    logic [WIDTH_LVL-1:0]    curbin_q, loadlvl_q, baselvl_q;
    logic                    baseen_q;

    logic beat;
    logic expired;

    assign beat = clause_valid_i & ready_q;

    sat_watchdog #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q != S_RUN),
        .en_i      (state_q == S_RUN),
        .expired_o (expired)
    );

    // Load/run sequencer; every engine-facing output is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            bin_q     <= '0;
            base_q    <= '0;
            vs_q      <= '0;
            ls_q      <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            unsat_q   <= 1'b0;
            tout_q    <= 1'b0;
            perr_q    <= 1'b0;
            bkt_q     <= '0;
            vsres_q   <= '0;
            wrc_q     <= '0;
            clause_q  <= '0;
            wrvs_q    <= '0;
            vso_q     <= '0;
            wrls_q    <= '0;
            lso_q     <= '0;
            stc_q     <= 1'b0;
            curbin_q  <= '0;
            loadlvl_q <= '0;
            baselvl_q <= '0;
            baseen_q  <= 1'b0;
        end else begin
            wrc_q     <= '0;
            clause_q  <= '0;
            wrvs_q    <= '0;
            vso_q     <= '0;
            wrls_q    <= '0;
            lso_q     <= '0;
            stc_q     <= 1'b0;
            curbin_q  <= '0;
            loadlvl_q <= '0;
            done_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        bin_q   <= bin_id_i;
                        base_q  <= base_lvl_i;
                        vs_q    <= vs_src_i;
                        ls_q    <= ls_src_i;
                        k_q     <= '0;
                        sat_q   <= 1'b0;
                        unsat_q <= 1'b0;
                        tout_q  <= 1'b0;
                        perr_q  <= 1'b0;
                        bkt_q   <= '0;
                        vsres_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD_C;
                    end
                end
                S_LOAD_C: begin
                    if (beat) begin
                        wrc_q    <= NUM_CLAUSES'(1) << k_q;
                        clause_q <= clause_data_i;
                        k_q      <= k_q + KW'(1);
                        if (k_q == K_LAST) begin
                            ready_q   <= 1'b0;
                            baseen_q  <= 1'b1;
                            baselvl_q <= base_q;
                            state_q   <= S_LOAD_VS;
                        end else if (clause_last_i) begin
                            ready_q <= 1'b0;
                            state_q <= S_PAD_C;
                        end
                    end
                end
                S_PAD_C: begin
                    wrc_q <= NUM_CLAUSES'(1) << k_q;
                    k_q   <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        baseen_q  <= 1'b1;
                        baselvl_q <= base_q;
                        state_q   <= S_LOAD_VS;
                    end
                end
                S_LOAD_VS: begin
                    wrvs_q  <= '1;
                    vso_q   <= vs_q;
                    state_q <= S_LOAD_LS;
                end
                S_LOAD_LS: begin
                    wrls_q  <= '1;
                    lso_q   <= ls_q;
                    state_q <= S_START;
                end
                S_START: begin
                    stc_q     <= 1'b1;
                    curbin_q  <= WIDTH_LVL'(bin_q);
                    loadlvl_q <= base_q;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    if (done_core_i) begin
                        sat_q     <= sat_i;
                        unsat_q   <= unsat_i;
                        perr_q    <= sat_i & unsat_i;
                        bkt_q     <= bkt_lvl_i;
                        vsres_q   <= vars_states_eng_i;
                        done_q    <= 1'b1;
                        baseen_q  <= 1'b0;
                        baselvl_q <= '0;
                        state_q   <= S_DONE;
                    end else if (expired) begin
                        tout_q    <= 1'b1;
                        done_q    <= 1'b1;
                        baseen_q  <= 1'b0;
                        baselvl_q <= '0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign clause_ready_o  = ready_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign sat_o           = sat_q;
    assign unsat_o         = unsat_q;
    assign timeout_o       = tout_q;
    assign proto_err_o     = perr_q;
    assign bkt_lvl_o       = bkt_q;
    assign vs_result_o     = vsres_q;
    assign wr_carray_o     = wrc_q;
    assign clause_o        = clause_q;
    assign wr_var_states_o = wrvs_q;
    assign vars_states_o   = vso_q;
    assign wr_lvl_states_o = wrls_q;
    assign lvl_states_o    = lso_q;
    assign start_core_o    = stc_q;
    assign cur_bin_num_o   = curbin_q;
    assign load_lvl_o      = loadlvl_q;
    assign base_lvl_o      = baselvl_q;
    assign base_lvl_en_o   = baseen_q;

endmodule

// File: tb/tb_sat_engine_loader.sv
// Directed bench for sat_engine_loader: load timing, padding,
// stalls, verdict capture, watchdog and mid-load reset.
module tb_sat_engine_loader;

    localparam int NC   = 8;
    localparam int NV   = 8;
    localparam int NL   = 8;
    localparam int WL   = 16;
    localparam int WB   = 10;
    localparam int WVS  = 19;
    localparam int WLS  = 11;
    localparam int MAXC = 16;
    localparam int VSW  = WVS * NV;
    localparam int LSW  = WLS * NL;
    localparam int CLW  = 2 * NV;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_i = 1'b0;
    logic [WB-1:0] bin_id_i = '0;
    logic [WL-1:0] base_lvl_i = '0;
    logic [VSW-1:0] vs_src_i = '0;
    logic [LSW-1:0] ls_src_i = '0;
    logic clause_valid_i = 1'b0;
    logic clause_last_i = 1'b0;
    logic [CLW-1:0] clause_data_i = '0;
    logic clause_ready_o, busy_o, done_o;
    logic sat_o, unsat_o, timeout_o, proto_err_o;
    logic [WL-1:0] bkt_lvl_o;
    logic [VSW-1:0] vs_result_o;
    logic [NC-1:0] wr_carray_o;
    logic [CLW-1:0] clause_o;
    logic [NV-1:0] wr_var_states_o;
    logic [VSW-1:0] vars_states_o;
    logic [NL-1:0] wr_lvl_states_o;
    logic [LSW-1:0] lvl_states_o;
    logic start_core_o;
    logic [WL-1:0] cur_bin_num_o, load_lvl_o, base_lvl_o;
    logic base_lvl_en_o;
    logic done_core_i = 1'b0;
    logic sat_i = 1'b0;
    logic unsat_i = 1'b0;
    logic [WL-1:0] bkt_lvl_i = '0;
    logic [VSW-1:0] vars_states_eng_i = '0;

    sat_engine_loader #(
        .NUM_CLAUSES(NC), .NUM_VARS(NV), .NUM_LVLS(NL),
        .WIDTH_LVL(WL), .WIDTH_BIN_ID(WB),
        .WIDTH_VAR_STATES(WVS), .WIDTH_LVL_STATES(WLS),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst_n),
        .start_i(start_i), .bin_id_i(bin_id_i),
        .base_lvl_i(base_lvl_i), .vs_src_i(vs_src_i),
        .ls_src_i(ls_src_i), .clause_valid_i(clause_valid_i),
        .clause_last_i(clause_last_i), .clause_data_i(clause_data_i),
        .clause_ready_o(clause_ready_o), .busy_o(busy_o),
        .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o),
        .timeout_o(timeout_o), .proto_err_o(proto_err_o),
        .bkt_lvl_o(bkt_lvl_o), .vs_result_o(vs_result_o),
        .wr_carray_o(wr_carray_o), .clause_o(clause_o),
        .wr_var_states_o(wr_var_states_o),
        .vars_states_o(vars_states_o),
        .wr_lvl_states_o(wr_lvl_states_o),
        .lvl_states_o(lvl_states_o), .start_core_o(start_core_o),
        .cur_bin_num_o(cur_bin_num_o), .load_lvl_o(load_lvl_o),
        .base_lvl_o(base_lvl_o), .base_lvl_en_o(base_lvl_en_o),
        .done_core_i(done_core_i), .sat_i(sat_i), .unsat_i(unsat_i),
        .bkt_lvl_i(bkt_lvl_i),
        .vars_states_eng_i(vars_states_eng_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [CLW-1:0] rows [8];
    logic [NC-1:0]  wr_log [24];
    logic [CLW-1:0] cl_log [24];
    int             wr_n, vs_t, ls_t;
    logic [VSW-1:0] vs_seen;
    logic [LSW-1:0] ls_seen;
    logic [NV-1:0]  wvs_seen;
    logic [NL-1:0]  wls_seen;
    logic [WL-1:0]  cb_seen, ll_seen, bl_seen;
    logic           ben_seen, ben_c1, sat_c1;

    // Call at a negedge; returns at the negedge start_core_o is seen.
    task automatic run_load(input int nrows, input int stall_at,
                            input int stall_len, output int t_sc);
        int beat;
        int stall;
        int c;
        beat = 0; stall = 0; c = 0; t_sc = -1;
        wr_n = 0; vs_t = -1; ls_t = -1;
        start_i = 1'b1;
        clause_valid_i = 1'b0;
        while (c < 80 && t_sc < 0) begin
            @(negedge clk);
            c++;
            start_i = 1'b0;
            if (c == 1) begin
                ben_c1 = base_lvl_en_o;
                sat_c1 = sat_o;
            end
            if (wr_carray_o != '0 && wr_n < 24) begin
                wr_log[wr_n] = wr_carray_o;
                cl_log[wr_n] = clause_o;
                wr_n++;
            end
            if (wr_var_states_o != '0) begin
                vs_t = c; vs_seen = vars_states_o;
                wvs_seen = wr_var_states_o;
            end
            if (wr_lvl_states_o != '0) begin
                ls_t = c; ls_seen = lvl_states_o;
                wls_seen = wr_lvl_states_o;
            end
            if (start_core_o) begin
                t_sc = c;
                cb_seen = cur_bin_num_o;
                ll_seen = load_lvl_o;
                ben_seen = base_lvl_en_o;
                bl_seen = base_lvl_o;
            end
            clause_valid_i = 1'b0;
            clause_last_i = 1'b0;
            if (clause_ready_o && beat < nrows) begin
                if (beat == stall_at && stall < stall_len) begin
                    stall++;
                end else begin
                    clause_valid_i = 1'b1;
                    clause_data_i = rows[beat];
                    clause_last_i = (beat == nrows - 1);
                    beat++;
                end
            end
        end
        clause_valid_i = 1'b0;
        clause_last_i = 1'b0;
    endtask

    // Drive one done_core_i beat and wait for done_o.
    task automatic finish_core(input logic s, input logic u,
                               input logic [WL-1:0] b,
                               input logic [VSW-1:0] v, output int n);
        done_core_i = 1'b1; sat_i = s; unsat_i = u;
        bkt_lvl_i = b; vars_states_eng_i = v;
        n = -1;
        for (int i = 1; i <= 30 && n < 0; i++) begin
            @(negedge clk);
            done_core_i = 1'b0;
            if (done_o) n = i;
        end
    endtask

    int t_sc, n;
    logic [VSW-1:0] vsa;
    logic [LSW-1:0] lsa;
    logic [VSW-1:0] eng_v;
    logic [NC-1:0] one;

    initial begin
        vsa   = {8{19'h5a3c1}};
        lsa   = {8{11'h6b5}};
        eng_v = {8{19'h2f00d}};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", clause_ready_o, 1'b0);
        chk("rst_wrc", wr_carray_o, 8'h00);
        chk("rst_done", done_o, 1'b0);
        chk("rst_start_core", start_core_o, 1'b0);
        chk("rst_base_en", base_lvl_en_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 8-row bin, no stalls; verdict SAT at level 5.
        rows[0] = 16'h1111; rows[1] = 16'h2222;
        rows[2] = 16'h3333; rows[3] = 16'h4444;
        rows[4] = 16'h5555; rows[5] = 16'h6666;
        rows[6] = 16'h7777; rows[7] = 16'h8888;
        bin_id_i = 10'h2a5; base_lvl_i = 16'h0033;
        vs_src_i = vsa; ls_src_i = lsa;
        run_load(8, -1, 0, t_sc);
        chk("a_start_core_edge", t_sc, 12);
        chk("a_base_en_idle", ben_c1, 1'b0);
        chk("a_writes", wr_n, 8);
        one = 8'h01;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_wrc%0d", i), wr_log[i], one);
            chk($sformatf("a_row%0d", i), cl_log[i], rows[i]);
            one = one << 1;
        end
        chk("a_vs_edge", vs_t, 10);
        chk("a_ls_edge", ls_t, 11);
        chk("a_wr_vs", wvs_seen, 8'hff);
        chk("a_wr_ls", wls_seen, 8'hff);
        chk("a_vs_data", vs_seen, vsa);
        chk("a_ls_data", ls_seen, lsa);
        chk("a_cur_bin", cb_seen, 16'h02a5);
        chk("a_load_lvl", ll_seen, 16'h0033);
        chk("a_base_en", ben_seen, 1'b1);
        chk("a_base_lvl", bl_seen, 16'h0033);
        @(negedge clk);
        chk("a_start_core_pulse", start_core_o, 1'b0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        finish_core(1'b1, 1'b0, 16'd5, eng_v, n);
        chk("a_done_lat", n, 1);
        chk("a_sat", sat_o, 1'b1);
        chk("a_unsat", unsat_o, 1'b0);
        chk("a_timeout", timeout_o, 1'b0);
        chk("a_perr", proto_err_o, 1'b0);
        chk("a_bkt", bkt_lvl_o, 16'd5);
        chk("a_vs_result", vs_result_o, eng_v);
        chk("a_done_base_en", base_lvl_en_o, 1'b0);
        @(negedge clk);
        chk("a_done_pulse", done_o, 1'b0);
        chk("a_idle_busy", busy_o, 1'b0);
        repeat (3) @(negedge clk);
        chk("a_run_start_ignored", clause_ready_o, 1'b0);
        chk("a_sat_hold", sat_o, 1'b1);
        chk("a_bkt_hold", bkt_lvl_o, 16'd5);

        // Three-row bin with padding; both verdict bits set.
        rows[0] = 16'h0012; rows[1] = 16'h0048;
        rows[2] = 16'h0220;
        bin_id_i = 10'h001; base_lvl_i = 16'h0007;
        run_load(3, -1, 0, t_sc);
        chk("b_results_cleared", sat_c1, 1'b0);
        chk("b_start_core_edge", t_sc, 12);
        chk("b_writes", wr_n, 8);
        one = 8'h01;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b_wrc%0d", i), wr_log[i], one);
            chk($sformatf("b_row%0d", i), cl_log[i],
                (i < 3) ? rows[i] : 16'h0000);
            one = one << 1;
        end
        chk("b_cur_bin", cb_seen, 16'h0001);
        finish_core(1'b1, 1'b1, 16'd2, eng_v, n);
        chk("b_perr", proto_err_o, 1'b1);
        chk("b_unsat", unsat_o, 1'b1);
        chk("b_timeout", timeout_o, 1'b0);
        @(negedge clk);

        // Stall of three cycles before row 4, then watchdog expiry.
        rows[0] = 16'ha001; rows[1] = 16'ha002;
        rows[2] = 16'ha003; rows[3] = 16'ha004;
        rows[4] = 16'ha005; rows[5] = 16'ha006;
        rows[6] = 16'ha007; rows[7] = 16'ha008;
        run_load(8, 4, 3, t_sc);
        chk("c_start_core_edge", t_sc, 15);
        chk("c_writes", wr_n, 8);
        chk("c_wrc4", wr_log[4], 8'h10);
        chk("c_row4", cl_log[4], 16'ha005);
        chk("c_wrc7", wr_log[7], 8'h80);
        n = -1;
        for (int i = 1; i <= 40 && n < 0; i++) begin
            @(negedge clk);
            if (done_o) n = i;
        end
        chk("c_timeout_lat", n, MAXC);
        chk("c_timeout", timeout_o, 1'b1);
        chk("c_sat", sat_o, 1'b0);
        chk("c_unsat", unsat_o, 1'b0);
        @(negedge clk);

        // done_core_i on the very edge the watchdog expires.
        run_load(8, -1, 0, t_sc);
        chk("d_start_core_edge", t_sc, 12);
        repeat (MAXC - 1) @(negedge clk);
        chk("d_still_busy", done_o, 1'b0);
        finish_core(1'b0, 1'b1, 16'd9, eng_v, n);
        chk("d_done_lat", n, 1);
        chk("d_timeout_tie", timeout_o, 1'b0);
        chk("d_unsat", unsat_o, 1'b1);
        chk("d_bkt", bkt_lvl_o, 16'd9);
        @(negedge clk);

        // Reset while row 4 is being written, then reload.
        start_i = 1'b1;
        n = 0;
        for (int c = 1; c <= 30 && n == 0; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            clause_valid_i = clause_ready_o;
            clause_data_i = 16'hbeef;
            if (wr_carray_o == 8'h10) n = c;
        end
        chk("e_row4_seen", n, 6);
        rst_n = 1'b0;
        #1;
        chk("e_rst_wrc", wr_carray_o, 8'h00);
        chk("e_rst_clause", clause_o, 16'h0000);
        chk("e_rst_busy", busy_o, 1'b0);
        chk("e_rst_ready", clause_ready_o, 1'b0);
        n = 0;
        repeat (2) begin
            @(negedge clk);
            if (wr_carray_o != '0) n++;
        end
        clause_valid_i = 1'b0;
        chk("e_no_writes", n, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("e_idle", busy_o, 1'b0);
        run_load(8, -1, 0, t_sc);
        chk("e_start_core_edge", t_sc, 12);
        chk("e_writes", wr_n, 8);
        chk("e_first_row", wr_log[0], 8'h01);
        chk("e_first_data", cl_log[0], rows[0]);
        finish_core(1'b1, 1'b0, 16'd1, eng_v, n);
        chk("e_done", n, 1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
